run_sequencer: RTL and testbench

- Program-run controller between the host/testbench and the single-cycle core.
- Sequences the core's Start/Ack handshake and counts executed cycles, with a timeout watchdog.
- Arbitrates the single data-memory port: the host owns it while the core is idle or done; the core owns it while running.
- Sits at top level, wrapping the core's Start, Ack and data-memory signals.

---
 rtl/run_sequencer_if.sv | 40 ++++
 rtl/run_sequencer.sv | 126 ++++++++++++
 tb/tb_run_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// Bundles the host, core and data-memory signals around run_sequencer.
// The slave modport is the sequencer's view. The master modport is the view
// of whatever drives the host and core sides.
interface run_sequencer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          host_req;
  logic          abort;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          core_start;
  logic          core_ack;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [15:0]   cycle_count;

  modport slave (
    input  host_req, abort, host_we, host_addr, host_wdata,
    input  core_ack, core_we, core_addr, core_wdata,
    output host_gnt, core_start, mem_we, mem_addr, mem_wdata,
    output busy, done, timed_out, cycle_count
  );

  modport master (
    output host_req, abort, host_we, host_addr, host_wdata,
    output core_ack, core_we, core_addr, core_wdata,
    input  host_gnt, core_start, mem_we, mem_addr, mem_wdata,
    input  busy, done, timed_out, cycle_count
  );
endinterface

// File: rtl/run_sequencer.sv
// Program-run controller. It sequences the core Start/Ack handshake, counts
// RUN cycles under a watchdog, and hands the single data-memory port to the
// host or to the core.
module run_sequencer #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input logic           clk,
  input logic           rst_n,
  run_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  localparam int unsigned SCW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0] StartLast = SCW'(START_CYCLES - 1);
  localparam logic [15:0]    TimeoutLast = TIMEOUT - 16'd1;

  state_e         state_q;
  logic [SCW-1:0] start_cnt_q;
  logic [15:0]    cycle_count_q;
  logic           core_start_q;
  logic           busy_q;
  logic           host_gnt_q;
  logic           done_q;
  logic           timed_out_q;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // Run FSM; every output is a register so nothing combinational reaches core_start or done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      start_cnt_q   <= '0;
      cycle_count_q <= '0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      host_gnt_q    <= 1'b1;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // host_req wins over abort here; abort has no effect outside a run
          if (bus.host_req) begin
            state_q       <= StStart;
            start_cnt_q   <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            core_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            host_gnt_q    <= 1'b0;
          end
        end
        StStart: begin
          // core_ack is stale during START and is ignored
          if (bus.abort) begin
            state_q      <= StIdle;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            host_gnt_q   <= 1'b1;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
          end else if (start_cnt_q == StartLast) begin
            state_q      <= StRun;
            core_start_q <= 1'b0;
          end else begin
            start_cnt_q <= start_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (bus.abort) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            host_gnt_q  <= 1'b1;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
          end else if (bus.core_ack) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            host_gnt_q <= 1'b1;
            done_q     <= 1'b1;
          end else if ((TIMEOUT != 16'd0) && (cycle_count_q == TimeoutLast)) begin
            state_q       <= StDone;
            busy_q        <= 1'b0;
            host_gnt_q    <= 1'b1;
            done_q        <= 1'b1;
            timed_out_q   <= 1'b1;
            cycle_count_q <= TIMEOUT;
          end else if (cycle_count_q != 16'hFFFF) begin
            cycle_count_q <= cycle_count_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory port mux; the side without the grant is dropped and never queued
  always_comb begin
    mem_we    = bus.core_we;
    mem_addr  = bus.core_addr;
    mem_wdata = bus.core_wdata;
    if (host_gnt_q) begin
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.core_start  = core_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer, built with a 20-cycle watchdog. A vector
// table covers the memory mux, and hand sequences cover the multi-cycle cases.
module tb_run_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  run_sequencer_if #(.AW(8), .DW(8)) bus ();

  run_sequencer #(
    .AW(8),
    .DW(8),
    .START_CYCLES(2),
    .TIMEOUT(16'd20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         run;
    logic       hwe;
    logic [7:0] ha;
    logic [7:0] hd;
    logic       cwe;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       gnt;
    logic       mwe;
    logic [7:0] ma;
    logic [7:0] md;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse host_req and step through both START cycles; ends in RUN with count 0
  task automatic launch();
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit launched;
    n_tests = 0;
    n_fail  = 0;
    launched = 1'b0;
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 8'h20, 8'h66, 1'b1, 1'b1, 8'h10, 8'h55};
    vecs[1] = '{1'b0, 1'b0, 8'h33, 8'hAA, 1'b1, 8'h44, 8'hBB, 1'b1, 1'b0, 8'h33, 8'hAA};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h11, 1'b1, 8'h20, 8'h22, 1'b0, 1'b1, 8'h20, 8'h22};
    vecs[3] = '{1'b1, 1'b1, 8'h10, 8'h11, 1'b0, 8'h30, 8'h33, 1'b0, 1'b0, 8'h30, 8'h33};
    vecs[4] = '{1'b1, 1'b0, 8'h77, 8'h88, 1'b1, 8'hFE, 8'hEF, 1'b0, 1'b1, 8'hFE, 8'hEF};

    bus.host_req   = 1'b0;
    bus.abort      = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.core_ack   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_core_start", 32'(bus.core_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_timed_out", 32'(bus.timed_out), 32'd0);
    check("rst_cycle_count", 32'(bus.cycle_count), 32'd0);
    check("rst_host_gnt", 32'(bus.host_gnt), 32'd1);

    // Memory mux vectors: idle ones first, then launch and apply the RUN ones
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].run && !launched) begin
        bus.host_we = 1'b0;
        bus.core_we = 1'b0;
        launch();
        launched = 1'b1;
      end
      bus.host_we    = vecs[i].hwe;
      bus.host_addr  = vecs[i].ha;
      bus.host_wdata = vecs[i].hd;
      bus.core_we    = vecs[i].cwe;
      bus.core_addr  = vecs[i].ca;
      bus.core_wdata = vecs[i].cd;
      #1;
      check($sformatf("vec%0d_host_gnt", i), 32'(bus.host_gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].mwe));
      check($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].ma));
      check($sformatf("vec%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].md));
      tick();
    end
    bus.host_we = 1'b0;
    bus.core_we = 1'b0;
    bus.abort   = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("vec_abort_busy", 32'(bus.busy), 32'd0);

    // Normal run: two START cycles, ack after 10 RUN cycles
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    check("norm_start1", 32'(bus.core_start), 32'd1);
    check("norm_busy", 32'(bus.busy), 32'd1);
    check("norm_gnt_start", 32'(bus.host_gnt), 32'd0);
    tick();
    check("norm_start2", 32'(bus.core_start), 32'd1);
    tick();
    check("norm_start_low", 32'(bus.core_start), 32'd0);
    check("norm_run_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("norm_count_pre_ack", 32'(bus.cycle_count), 32'd10);
    check("norm_done_pre_ack", 32'(bus.done), 32'd0);
    bus.core_ack = 1'b1;
    tick();
    bus.core_ack = 1'b0;
    check("norm_done", 32'(bus.done), 32'd1);
    check("norm_timed_out", 32'(bus.timed_out), 32'd0);
    check("norm_count", 32'(bus.cycle_count), 32'd10);
    check("norm_gnt", 32'(bus.host_gnt), 32'd1);
    check("norm_busy_end", 32'(bus.busy), 32'd0);

    // Host write in DONE owns the port
    bus.host_we   = 1'b1;
    bus.host_addr = 8'h10;
    bus.core_we   = 1'b1;
    bus.core_addr = 8'h20;
    #1;
    check("done_mem_we", 32'(bus.mem_we), 32'd1);
    check("done_mem_addr", 32'(bus.mem_addr), 32'h10);
    bus.host_we = 1'b0;
    bus.core_we = 1'b0;

    // Abort is ignored in DONE
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("done_abort_done", 32'(bus.done), 32'd1);
    check("done_abort_count", 32'(bus.cycle_count), 32'd10);

    // Watchdog expiry after 20 RUN cycles
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    check("relaunch_done_clr", 32'(bus.done), 32'd0);
    check("relaunch_count_clr", 32'(bus.cycle_count), 32'd0);
    check("relaunch_start", 32'(bus.core_start), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 19; i++) tick();
    check("wd_count19", 32'(bus.cycle_count), 32'd19);
    check("wd_not_done", 32'(bus.done), 32'd0);
    tick();
    check("wd_done", 32'(bus.done), 32'd1);
    check("wd_timed_out", 32'(bus.timed_out), 32'd1);
    check("wd_count", 32'(bus.cycle_count), 32'd20);

    // Ack on the watchdog cycle wins
    launch();
    check("wd2_timed_out_clr", 32'(bus.timed_out), 32'd0);
    for (int i = 0; i < 19; i++) tick();
    bus.core_ack = 1'b1;
    tick();
    bus.core_ack = 1'b0;
    check("wd2_done", 32'(bus.done), 32'd1);
    check("wd2_timed_out", 32'(bus.timed_out), 32'd0);
    check("wd2_count", 32'(bus.cycle_count), 32'd19);

    // Stale ack held from before launch
    bus.core_ack = 1'b1;
    tick();
    launch();
    check("stale_in_run_busy", 32'(bus.busy), 32'd1);
    check("stale_in_run_done", 32'(bus.done), 32'd0);
    tick();
    bus.core_ack = 1'b0;
    check("stale_done", 32'(bus.done), 32'd1);
    check("stale_count", 32'(bus.cycle_count), 32'd0);

    // Abort in RUN cycle 3
    launch();
    for (int i = 0; i < 3; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_count", 32'(bus.cycle_count), 32'd3);
    check("abort_gnt", 32'(bus.host_gnt), 32'd1);
    tick();
    check("abort_idle_stays", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-run
    launch();
    for (int i = 0; i < 5; i++) tick();
    check("rmid_count5", 32'(bus.cycle_count), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check("rmid_core_start", 32'(bus.core_start), 32'd0);
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_done", 32'(bus.done), 32'd0);
    check("rmid_count", 32'(bus.cycle_count), 32'd0);
    check("rmid_gnt", 32'(bus.host_gnt), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rmid_after_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
